// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, per-frame key detection,
// press/release debounce FSM and encoding into digit_valid/submit/clear pulses.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    input  logic       ready_for_input,
    output logic [3:0] col_n,
    output logic [3:0] digit_in,
    output logic       digit_valid,
    output logic       submit,
    output logic       clear,
    output logic       key_busy
);
    localparam int unsigned DW_W  = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    state_t            state, state_next;
    logic [3:0]        row_s1, row_s2;
    logic [DW_W-1:0]   dwell;
    logic [1:0]        col;
    logic [1:0]        hits, hits_next;
    logic [3:0]        key, key_next;
    logic [2:0]        col_hits;
    logic [1:0]        col_row;
    logic [3:0]        cand, cand_next;
    logic [CNT_W-1:0]  cnt, cnt_next, rel, rel_next;
    logic              tick, frame_end, accept;
    logic              is_digit, is_submit, is_clear;
    logic [3:0]        digit_val;

    assign tick      = (dwell == DWELL_LAST);
    assign frame_end = tick && (col == 2'd3);
    assign col_n     = ~(4'b0001 << col);
    assign key_busy  = (state != IDLE);

    // hits saturates at 2: 0 = NONE, 1 = SINGLE (key holds its index), 2 = MULTI
    always_comb begin
        col_hits  = '0;
        col_row   = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        hits_next = hits;
        key_next  = key;
        if (col_hits != 3'd0) begin
            if (hits == 2'd0 && col_hits == 3'd1) begin
                hits_next = 2'd1;
                key_next  = {col_row, col};
            end else begin
                hits_next = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_s1 <= '1;
            row_s2 <= '1;
            dwell  <= '0;
            col    <= '0;
            hits   <= '0;
            key    <= '0;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            if (tick) begin
                dwell <= '0;
                col   <= col + 2'd1;
                hits  <= (col == 2'd3) ? 2'd0 : hits_next;
                key   <= key_next;
            end else begin
                dwell <= dwell + DW_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            rel   <= '0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            rel   <= rel_next;
        end
    end

    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        rel_next   = rel;
        accept     = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (hits_next == 2'd1) begin
                        cand_next = key_next;
                        cnt_next  = CNT_W'(1);
                        if (CNT_LAST == '0) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                            rel_next   = '0;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hits_next == 2'd1 && key_next == cand) begin
                        if (cnt == CNT_LAST) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                            rel_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (hits_next == 2'd0) begin
                        if (rel == CNT_LAST) begin
                            state_next = IDLE;
                            rel_next   = '0;
                        end else begin
                            rel_next = rel + CNT_W'(1);
                        end
                    end else begin
                        rel_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Layout: r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: * 0 # D
    always_comb begin
        is_digit  = 1'b1;
        is_submit = 1'b0;
        is_clear  = 1'b0;
        digit_val = '0;
        case (cand_next)
            4'd0:    digit_val = 4'd1;
            4'd1:    digit_val = 4'd2;
            4'd2:    digit_val = 4'd3;
            4'd4:    digit_val = 4'd4;
            4'd5:    digit_val = 4'd5;
            4'd6:    digit_val = 4'd6;
            4'd8:    digit_val = 4'd7;
            4'd9:    digit_val = 4'd8;
            4'd10:   digit_val = 4'd9;
            4'd13:   digit_val = 4'd0;
            4'd12: begin is_digit = 1'b0; is_clear  = 1'b1; end
            4'd14: begin is_digit = 1'b0; is_submit = 1'b1; end
            default: is_digit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_in    <= '0;
            digit_valid <= 1'b0;
            submit      <= 1'b0;
            clear       <= 1'b0;
        end else begin
            digit_valid <= accept && ready_for_input && is_digit;
            submit      <= accept && ready_for_input && is_submit;
            clear       <= accept && ready_for_input && is_clear;
            if (accept && ready_for_input && is_digit)
                digit_in <= digit_val;
        end
    end
endmodule
